attention_sequencer: RTL and testbench

Schedules one attention pass per row through the shared processor datapath. For each row it runs four stages in fixed order: mode 00 Q*K, 01 Scale, 10 Softmax, 11 V. Stage n's result vector is chained as operand A of stage n+1. Sits between the AXI wrapper's command/operand memory side and the processor; fetches operands through a request/valid handshake and emits one result row per input row under backpressure, with a watchdog on every processor pass.

---
 rtl/attention_sequencer_pkg.sv | 24 ++
 rtl/attention_sequencer_watchdog.sv | 32 +++
 rtl/attention_sequencer.sv | 163 ++++++++++++++++
 tb/tb_attention_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/attention_sequencer_pkg.sv
// Shared encodings for the attention sequencer: stage codes (identical to the
// processor mode field) and the sequencer state set.
package attn_pkg;

  localparam int NUM_STAGES = 4;

  typedef enum logic [1:0] {
    QK      = 2'b00,
    SCALE   = 2'b01,
    SOFTMAX = 2'b10,
    VMUL    = 2'b11
  } stage_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_PROC = 3'd3,
    S_EMIT      = 3'd4,
    S_DONE      = 3'd5,
    S_ERROR     = 3'd6
  } seq_state_t;

endpackage

// File: rtl/attention_sequencer_watchdog.sv
// Per-pass watchdog: counts cycles spent waiting on the processor and flags
// expiry on the cycle the count would reach TIMEOUT-1.
module seq_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] r_count;
  logic          w_hit;

  // r_count holds (cycles in wait - 1), so the compare is against TIMEOUT-2
  assign w_hit     = (r_count == CW'(TIMEOUT - 2));
  assign o_expired = i_en && w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_hit) begin
      r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/attention_sequencer.sv
// Runs the four attention stages (QK, scale, softmax, V) per row through the
// shared processor, chaining each stage result into the next stage's operand A.
module attention_sequencer
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int MATRIX_SIZE = 16,
  parameter int ROW_W       = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_start,
  input  logic [ROW_W-1:0]                  cmd_rows,
  input  logic                              cmd_abort,
  output logic                              busy,
  output logic                              cmd_done,
  output logic                              cmd_error,
  output logic                              opnd_req,
  output logic [ROW_W-1:0]                  opnd_row,
  output logic [1:0]                        opnd_stage,
  input  logic                              opnd_valid,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] opnd_a,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] opnd_b,
  output logic                              proc_start,
  output logic [1:0]                        proc_mode,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0] proc_a,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0] proc_b,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] proc_data,
  input  logic                              proc_done,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [ROW_W-1:0]                  res_row,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0] res_data
);

  localparam int VEC_W = DATA_WIDTH * MATRIX_SIZE;

  seq_state_t       r_state;
  seq_state_t       w_next;
  stage_t           r_stage;
  stage_t           r_mode;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] r_rows;
  logic [ROW_W-1:0] r_res_row;
  logic [VEC_W-1:0] r_proc_a;
  logic [VEC_W-1:0] r_proc_b;
  logic [VEC_W-1:0] r_res_data;
  logic             r_cmd_done;
  logic             r_cmd_error;
  logic [ROW_W:0]   w_row_inc;
  logic             w_last;
  logic             w_expired;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (r_state == S_LAUNCH),
    .i_en      (r_state == S_WAIT_PROC),
    .o_expired (w_expired)
  );

  // Extra bit keeps the last-row compare exact even when rows = 2^ROW_W-1
  assign w_row_inc = {1'b0, r_row} + {{ROW_W{1'b0}}, 1'b1};
  assign w_last    = (w_row_inc == {1'b0, r_rows});

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (cmd_start) w_next = (cmd_rows == '0) ? S_DONE : S_FETCH;
      S_FETCH:     if (opnd_valid) w_next = S_LAUNCH;
      S_LAUNCH:    w_next = S_WAIT_PROC;
      S_WAIT_PROC: begin
        if (proc_done)      w_next = (r_stage == VMUL) ? S_EMIT : S_FETCH;
        else if (w_expired) w_next = S_ERROR;
      end
      S_EMIT:      if (res_ready) w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:      w_next = S_IDLE;
      S_ERROR:     w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    if (cmd_abort && (r_state == S_FETCH || r_state == S_LAUNCH ||
                      r_state == S_WAIT_PROC || r_state == S_EMIT)) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_stage     <= QK;
      r_mode      <= QK;
      r_row       <= '0;
      r_rows      <= '0;
      r_res_row   <= '0;
      r_proc_a    <= '0;
      r_proc_b    <= '0;
      r_res_data  <= '0;
      r_cmd_done  <= 1'b0;
      r_cmd_error <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cmd_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (cmd_start) begin
            r_rows      <= cmd_rows;
            r_row       <= '0;
            r_stage     <= QK;
            r_cmd_error <= 1'b0;
          end
        end
        S_FETCH: begin
          // proc_mode is loaded on entry to LAUNCH and otherwise held
          if (opnd_valid && !cmd_abort) begin
            r_proc_b <= opnd_b;
            if (r_stage == QK) r_proc_a <= opnd_a;
            r_mode <= r_stage;
          end
        end
        S_WAIT_PROC: begin
          if (!cmd_abort) begin
            if (proc_done) begin
              if (r_stage != VMUL) begin
                r_proc_a <= proc_data;
                r_stage  <= stage_t'(r_stage + 2'd1);
              end else begin
                r_res_data <= proc_data;
                r_res_row  <= r_row;
              end
            end else if (w_expired) begin
              r_cmd_error <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (res_ready && !cmd_abort && !w_last) begin
            r_row   <= w_row_inc[ROW_W-1:0];
            r_stage <= QK;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign cmd_done   = r_cmd_done;
  assign cmd_error  = r_cmd_error;
  assign opnd_req   = (r_state == S_FETCH);
  assign opnd_row   = r_row;
  assign opnd_stage = r_stage;
  assign proc_start = (r_state == S_LAUNCH);
  assign proc_mode  = r_mode;
  assign proc_a     = r_proc_a;
  assign proc_b     = r_proc_b;
  assign res_valid  = (r_state == S_EMIT);
  assign res_row    = r_res_row;
  assign res_data   = r_res_data;

endmodule

// File: tb/tb_attention_sequencer.sv
// Randomized bench for attention_sequencer: memory and processor models drive
// the handshakes, a chained-stage reference predicts every operand and result.
module tb_attention_sequencer;

  localparam int DW   = 16;
  localparam int MS   = 16;
  localparam int RW   = 8;
  localparam int TO   = 32;
  localparam int VW   = DW * MS;
  localparam int MAXR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_start, cmd_abort, opnd_valid, proc_done, res_ready;
  logic [RW-1:0] cmd_rows;
  logic          busy, cmd_done, cmd_error, opnd_req, proc_start, res_valid;
  logic [RW-1:0] opnd_row, res_row;
  logic [1:0]    opnd_stage, proc_mode;
  logic [VW-1:0] opnd_a, opnd_b, proc_a, proc_b, proc_data, res_data;

  attention_sequencer #(
    .DATA_WIDTH(DW), .MATRIX_SIZE(MS), .ROW_W(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_rows(cmd_rows),
    .cmd_abort(cmd_abort), .busy(busy), .cmd_done(cmd_done), .cmd_error(cmd_error),
    .opnd_req(opnd_req), .opnd_row(opnd_row), .opnd_stage(opnd_stage),
    .opnd_valid(opnd_valid), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .proc_start(proc_start), .proc_mode(proc_mode), .proc_a(proc_a), .proc_b(proc_b),
    .proc_data(proc_data), .proc_done(proc_done), .res_valid(res_valid),
    .res_ready(res_ready), .res_row(res_row), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [VW-1:0] memA [MAXR];
  logic [VW-1:0] memB [MAXR][4];
  int  lat_lo = 2, lat_hi = 20;
  bit  hang = 0, long_d2 = 0;
  int  mrow = 0, mstage = 0, n_start = 0, n_req = 0, t_start = 0;

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Processor stage function: any deterministic mix of a, b and the mode.
  function automatic logic [VW-1:0] pf(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                       input logic [1:0] m);
    logic [VW-1:0] r;
    for (int i = 0; i < MS; i++)
      r[i*DW +: DW] = a[i*DW +: DW] * 16'd3 + b[i*DW +: DW] + {14'd0, m};
    return r;
  endfunction

  // Operand A seen by stage n of a row: A chained through the first n stages.
  function automatic logic [VW-1:0] chain(input int row, input int n);
    logic [VW-1:0] x;
    x = memA[row];
    for (int k = 0; k < n; k++) x = pf(x, memB[row][k], 2'(k));
    return x;
  endfunction

  task automatic fill_mem();
    for (int r = 0; r < MAXR; r++) begin
      for (int w = 0; w < VW/32; w++) memA[r][w*32 +: 32] = $urandom();
      for (int s = 0; s < 4; s++)
        for (int w = 0; w < VW/32; w++) memB[r][s][w*32 +: 32] = $urandom();
    end
  endtask

  // Processor model plus launch monitor.
  initial begin
    logic [VW-1:0] res;
    int lat;
    proc_done = 1'b0;
    proc_data = '0;
    forever begin
      @(negedge clk);
      if (proc_start === 1'b1) begin
        t_start = cyc;
        n_start++;
        check_eq("proc_mode", proc_mode, mstage);
        check_eq("proc_a", proc_a, chain(mrow, mstage));
        check_eq("proc_b", proc_b, memB[mrow][mstage]);
        res = pf(proc_a, proc_b, proc_mode);
        if (mstage == 3) begin mstage = 0; mrow++; end
        else mstage++;
        if (!hang) begin
          lat = $urandom_range(lat_lo, lat_hi);
          repeat (lat - 1) @(negedge clk);
          proc_done = 1'b1;
          proc_data = res;
          @(negedge clk);
          proc_done = 1'b0;
        end
      end
    end
  end

  // Operand memory model with randomized response delay.
  initial begin
    int r, s, d, bad;
    opnd_valid = 1'b0;
    opnd_a = '0;
    opnd_b = '0;
    forever begin
      @(negedge clk);
      if (opnd_req === 1'b1) begin
        r = opnd_row;
        s = opnd_stage;
        n_req++;
        check_eq("opnd_row", r, mrow);
        check_eq("opnd_stage", s, mstage);
        d = (s == 2 && long_d2) ? 7 : $urandom_range(0, 2);
        bad = 0;
        repeat (d) begin
          @(negedge clk);
          if (opnd_req !== 1'b1 || opnd_row != r || opnd_stage != s || proc_start !== 1'b0) bad++;
        end
        check_eq("opnd_hold", bad, 0);
        opnd_valid = 1'b1;
        opnd_a = memA[r % MAXR];
        opnd_b = memB[r % MAXR][s];
        @(negedge clk);
        opnd_valid = 1'b0;
      end
    end
  end

  task automatic run_job(input int rows, input int stall_row, input int stall_cyc,
                         input int abort_k, input int rst_row);
    logic [VW-1:0] hold_d;
    int hold_r, bad, stalled, exp_row, budget, starts_seen;
    bit fin;
    mrow = 0; mstage = 0; n_start = 0;
    cmd_rows = RW'(rows);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    check_eq("busy_on_start", busy, 1);
    check_eq("err_cleared", cmd_error, 0);
    exp_row = 0; bad = 0; stalled = 0; budget = 0; starts_seen = 0; fin = 0;
    hold_d = '0; hold_r = 0;
    while (!fin && budget < 3000) begin
      res_ready = 1'b0;
      if (proc_start === 1'b1) begin
        starts_seen++;
        if (starts_seen == abort_k + 1) begin
          @(negedge clk);
          cmd_abort = 1'b1;
          @(negedge clk);
          cmd_abort = 1'b0;
          check_eq("abort_idle", {busy, opnd_req, proc_start, res_valid, cmd_done, cmd_error}, 0);
          bad = 0;
          repeat (25) begin
            @(negedge clk);
            if (cmd_done !== 1'b0 || cmd_error !== 1'b0 || busy !== 1'b0) bad++;
          end
          check_eq("abort_quiet", bad, 0);
          fin = 1;
        end
      end
      if (!fin && res_valid === 1'b1) begin
        if (res_row == rst_row) begin
          rst_n = 1'b0;
          #1;
          check_eq("rst_ctrl", {busy, cmd_done, cmd_error, opnd_req, proc_start, res_valid,
                                proc_mode, res_row}, 0);
          check_eq("rst_data", proc_a | proc_b | res_data, 0);
          @(negedge clk);
          rst_n = 1'b1;
          check_eq("rst_idle", busy, 0);
          fin = 1;
        end else if (res_row == stall_row && stalled < stall_cyc) begin
          if (stalled == 0) begin hold_d = res_data; hold_r = res_row; end
          else if (res_data !== hold_d || res_row != hold_r) bad++;
          stalled++;
        end else begin
          if (stalled > 0 && res_row == stall_row) begin
            if (res_data !== hold_d || res_row != hold_r) bad++;
            check_eq("stall_hold", bad, 0);
          end
          check_eq("res_row", res_row, exp_row);
          check_eq("res_data", res_data, chain(exp_row, 4));
          res_ready = 1'b1;
          exp_row++;
        end
      end
      if (!fin && cmd_done === 1'b1) begin
        check_eq("done_after_last", exp_row, rows);
        check_eq("n_start", n_start, 4 * rows);
        check_eq("no_error", cmd_error, 0);
        @(negedge clk);
        check_eq("done_pulse", {cmd_done, busy}, 0);
        fin = 1;
      end
      if (!fin) begin
        @(negedge clk);
        budget++;
      end
    end
    check_eq("job_budget", budget < 3000, 1);
    res_ready = 1'b0;
  endtask

  initial begin
    int t_err, budget, bad, req0;
    rst_n = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0; cmd_rows = '0; res_ready = 1'b0;
    fill_mem();
    repeat (3) @(negedge clk);
    check_eq("reset_ctrl", {busy, cmd_done, cmd_error, opnd_req, proc_start, res_valid,
                            proc_mode, opnd_stage, opnd_row, res_row}, 0);
    check_eq("reset_data", proc_a | proc_b | res_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single row, all-ones A, tagged B, fixed 20-cycle processor
    for (int s = 0; s < 4; s++) memB[0][s] = {MS{16'h1000 * 16'(s + 1)}};
    memA[0] = {MS{16'h0100}};
    lat_lo = 20; lat_hi = 20;
    run_job(1, -1, 0, -1, -1);

    // three rows with a 10-cycle downstream stall on row 1
    fill_mem();
    lat_lo = 2; lat_hi = 20;
    run_job(3, 1, 10, -1, -1);

    // zero rows: done two cycles after start, no traffic
    n_start = 0; req0 = n_req;
    cmd_rows = '0; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    check_eq("zero_rows_c1", {cmd_done, busy}, 2'b01);
    @(negedge clk);
    check_eq("zero_rows_c2", {cmd_done, busy}, 2'b10);
    @(negedge clk);
    check_eq("zero_rows_c3", cmd_done, 0);
    check_eq("zero_rows_traffic", {n_req - req0, n_start}, 0);

    // watchdog expiry with a silent processor
    fill_mem();
    hang = 1; mrow = 0; mstage = 0; n_start = 0;
    cmd_rows = 8'd1; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    budget = 0; bad = 0;
    while (cmd_error !== 1'b1 && budget < 200) begin
      if (cmd_done === 1'b1) bad++;
      @(negedge clk);
      budget++;
    end
    t_err = cyc;
    check_eq("wd_seen", budget < 200, 1);
    check_eq("wd_latency", t_err - t_start, TO);
    check_eq("wd_one_start", n_start, 1);
    @(negedge clk);
    check_eq("wd_idle", {busy, cmd_error, cmd_done}, 3'b010);
    check_eq("wd_no_done", bad, 0);
    hang = 0;

    // fresh start after error clears it; long operand wait at stage 2
    fill_mem();
    long_d2 = 1;
    run_job(2, -1, 0, -1, -1);
    long_d2 = 0;

    // abort in WAIT_PROC of row 1 stage 1, coinciding with proc_done
    fill_mem();
    lat_lo = 2; lat_hi = 2;
    run_job(3, -1, 0, 5, -1);
    lat_lo = 2; lat_hi = 20;
    run_job(2, -1, 0, -1, -1);

    // asynchronous reset while row 1 sits in EMIT
    fill_mem();
    run_job(2, 1, 50, -1, 1);
    run_job(1, -1, 0, -1, -1);

    for (int j = 0; j < 4; j++) begin
      fill_mem();
      run_job($urandom_range(1, MAXR), $urandom_range(0, MAXR - 1), $urandom_range(0, 6), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
